// File: rtl/sseg_arb_pkg.sv
// Shared types for the seven-segment display arbiter: FSM state encoding,
// client identifier and the state each client owns.
package sseg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic client_id_t;

  localparam int NUM_CLIENTS = 2;

  function automatic arb_state_t own_state(input client_id_t id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sseg_hold_timer.sv
// Minimum-ownership timer: loads on grant, counts down while someone owns the
// display and saturates at zero; expired marks the hold as used up.
module sseg_hold_timer #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum hold
// time; latches the owner's hex word and drives the digit mux plus a blank flag.
module sseg_display_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic        req0_rel,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic        req1_rel,
  output logic        req1_ready,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic        blank,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Handshake: a word moves when reqN_valid & reqN_ready are both high at a
  // clock edge. reqN_ready depends only on the state register, never on inputs;
  // valid may rise or fall freely and data is only sampled on a transfer.

  arb_state_t state;
  arb_state_t next_state;
  client_id_t last_owner;
  logic [15:0] hex_word;
  logic        grant;
  logic        hold_expired;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_owner)) begin
          next_state = OWN0;
        end else if (req1_valid) begin
          next_state = OWN1;
        end
      end
      OWN0: begin
        if (req0_rel) begin
          next_state = req1_valid ? OWN1 : IDLE;
        end else if (hold_expired && req1_valid) begin
          next_state = OWN1;
        end
      end
      OWN1: begin
        if (req1_rel) begin
          next_state = req0_valid ? OWN0 : IDLE;
        end else if (hold_expired && req0_valid) begin
          next_state = OWN0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Any transition into an owning state (from IDLE or a direct switch) is a grant.
  assign grant = (next_state != state) && (next_state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hex_word   <= '0;
      blank      <= 1'b1;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state <= next_state;
      blank <= (next_state == IDLE);
      if (grant) begin
        owner      <= (next_state == own_state(1'b1));
        last_owner <= (next_state == own_state(1'b1));
      end
      // Ready was high this cycle, so the word is taken even on release/switch.
      if ((state == OWN0) && req0_valid) begin
        hex_word <= req0_data;
      end else if ((state == OWN1) && req1_valid) begin
        hex_word <= req1_data;
      end
    end
  end

  sseg_hold_timer #(
    .WIDTH    (HOLD_W),
    .LOAD_VAL (HOLD_LOAD)
  ) u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant),
    .dec     (state != IDLE),
    .expired (hold_expired)
  );

  assign req0_ready = (state == OWN0);
  assign req1_ready = (state == OWN1);
  assign hex0       = hex_word[3:0];
  assign hex1       = hex_word[7:4];
  assign hex2       = hex_word[11:8];
  assign hex3       = hex_word[15:12];
  assign dbg_state  = state;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with HOLD_CYCLES=4: reset, single
// grant, tie break and round robin, hold timing, release and ignored inputs.
module tb_sseg_display_arbiter;
  import sseg_arb_pkg::*;

  localparam int HOLD = 4;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_rel, req0_ready;
  logic        req1_valid, req1_rel, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  hex0, hex1, hex2, hex3;
  logic        blank, owner;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  sseg_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_rel   (req0_rel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_rel   (req1_rel),
    .req1_ready (req1_ready),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .blank      (blank),
    .owner      (owner),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: hex word expectations are queued then popped when compared
  task automatic expect_hex(input logic [15:0] word);
    exp_q.push_back(word);
  endtask

  task automatic check_hex(input string tag);
    logic [15:0] exp_word;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      exp_word = exp_q.pop_front();
      check(tag, {16'd0, hex3, hex2, hex1, hex0}, {16'd0, exp_word});
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_rel = 1'b0; req0_data = 16'h0;
    req1_valid = 1'b0; req1_rel = 1'b0; req1_data = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_owner(input string tag, input arb_state_t st);
    check({tag, "_state"}, 32'(dbg_state), 32'(st));
    check({tag, "_rdy0"}, 32'(req0_ready), 32'(st == OWN0));
    check({tag, "_rdy1"}, 32'(req1_ready), 32'(st == OWN1));
    check({tag, "_blank"}, 32'(blank), 32'(st == IDLE));
    if (st != IDLE) check({tag, "_owner"}, 32'(owner), 32'(st == OWN1));
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    expect_hex(16'h0000); check_hex("rst_hex");

    // single requester
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h1234;
    tick();
    check_owner("t2_grant", OWN0);
    expect_hex(16'h0000); check_hex("t2_hex_before");
    tick();
    expect_hex(16'h1234); check_hex("t2_hex_after");
    check("t2_hex3", 32'(hex3), 32'h1);
    check("t2_hex0", 32'(hex0), 32'h4);

    // release with a transfer, other client idle
    req0_data = 16'hA5A5; req0_rel = 1'b1;
    tick();
    check_owner("t5_rel", IDLE);
    expect_hex(16'hA5A5); check_hex("t5_hex");

    // rel and data in IDLE are ignored
    idle_inputs();
    req0_rel = 1'b1; req1_rel = 1'b1; req1_data = 16'hFFFF; req0_data = 16'hEEEE;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_owner("t6_idle_rel", IDLE);
      expect_hex(16'hA5A5); check_hex("t6_idle_hex");
    end
    idle_inputs();

    // both valid from reset: client 0 wins, switch after HOLD cycles
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_data = 16'hBEEF;
    tick();
    check_owner("t3_grant0", OWN0);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check_owner("t3_hold0", OWN0);
    end
    expect_hex(16'h1111); check_hex("t3_hex0");
    tick();
    check_owner("t3_switch1", OWN1);
    expect_hex(16'h1111); check_hex("t3_hex_sw");
    tick();
    expect_hex(16'hBEEF); check_hex("t3_hex1");
    // asynchronous reset while OWN1
    #2;
    reset_n = 1'b0;
    #1;
    check_owner("t1_async_rst", IDLE);
    expect_hex(16'h0000); check_hex("t1_rst_hex");
    reset_n = 1'b1;
    idle_inputs();

    // hold timing, non-owner data/rel ignored, round robin back, no timeout
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h0C0C;
    tick();
    check_owner("t4_grant0", OWN0);
    req1_valid = 1'b1; req1_data = 16'h7777; req1_rel = 1'b1;
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check_owner("t4_hold", OWN0);
      expect_hex(16'h0C0C); check_hex("t4_nonowner_hex");
    end
    req1_rel = 1'b0;
    tick();
    check_owner("t4_switch", OWN1);
    tick();
    expect_hex(16'h7777); check_hex("t4_hex1");
    req1_valid = 1'b0; req0_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_owner("t4_no_timeout", OWN1);
    end
    req0_valid = 1'b1; req0_data = 16'h5A5A;
    tick();
    check_owner("t4_back0", OWN0);
    tick();
    expect_hex(16'h5A5A); check_hex("t4_hex_back");
    // release straight to the waiting client: zero idle cycles
    req1_valid = 1'b1; req0_rel = 1'b1;
    tick();
    check_owner("t4_rel_switch", OWN1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
